// File: rtl/cmp_pkg.sv
// Shared encodings for the team's magnitude comparators: one-hot result codes
// and the serial comparator's state encoding.
package cmp_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/cmp_shift_reg.sv
// Load / shift-left register pair holding the two operands; the current MSBs
// are the bits under comparison.
module cmp_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             msb_a,
    output logic             msb_b
);

    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] a_next, b_next;

    // Per-bit next value: load wins, otherwise take the neighbour below on a shift.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign a_next[gi] = load ? a_in[gi] : (shift ? 1'b0 : a_reg[gi]);
                assign b_next[gi] = load ? b_in[gi] : (shift ? 1'b0 : b_reg[gi]);
            end else begin : g_upper
                assign a_next[gi] = load ? a_in[gi] : (shift ? a_reg[gi-1] : a_reg[gi]);
                assign b_next[gi] = load ? b_in[gi] : (shift ? b_reg[gi-1] : b_reg[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            a_reg <= a_next;
            b_reg <= b_next;
        end
    end

    assign msb_a = a_reg[WIDTH-1];
    assign msb_b = b_reg[WIDTH-1];

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator (unsigned or two's complement)
// with optional early exit on the first differing bit.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 out,
    output logic [$clog2(WIDTH+1)-1:0] bits_examined
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    cmp_state_t      state_reg, state_next;
    logic [IW-1:0]   idx_reg;
    logic            decided_reg;
    logic            dec_gt_reg;
    logic            signed_reg;
    logic [2:0]      out_reg;
    logic [BW-1:0]   bits_reg;

    logic msb_a, msb_b;
    logic load, shift;
    logic diff, is_msb, gt_now, last_bit, finish;
    logic res_decided, res_gt;

    assign load  = (state_reg == IDLE) && start;
    assign shift = (state_reg == COMPARE);

    cmp_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .a_in  (A),
        .b_in  (B),
        .msb_a (msb_a),
        .msb_b (msb_b)
    );

    // The sign bit carries negative weight, so its polarity flips in signed mode.
    assign diff        = msb_a ^ msb_b;
    assign is_msb      = (idx_reg == IW'(WIDTH - 1));
    assign gt_now      = (signed_reg && is_msb) ? msb_b : msb_a;
    assign last_bit    = (idx_reg == '0);
    assign finish      = last_bit || (EARLY_EXIT && diff);
    assign res_decided = decided_reg || diff;
    assign res_gt      = decided_reg ? dec_gt_reg : gt_now;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)  state_next = COMPARE;
            COMPARE: if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg     <= '0;
            decided_reg <= 1'b0;
            dec_gt_reg  <= 1'b0;
            signed_reg  <= 1'b0;
            out_reg     <= CMP_NONE;
            bits_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        signed_reg  <= signed_mode;
                        idx_reg     <= IW'(WIDTH - 1);
                        decided_reg <= 1'b0;
                        dec_gt_reg  <= 1'b0;
                        bits_reg    <= '0;
                        out_reg     <= CMP_NONE;
                    end
                end
                COMPARE: begin
                    bits_reg <= bits_reg + 1'b1;
                    idx_reg  <= idx_reg - 1'b1;
                    // Only the first difference counts; later ones are ignored.
                    if (diff && !decided_reg) begin
                        decided_reg <= 1'b1;
                        dec_gt_reg  <= gt_now;
                    end
                    if (finish) begin
                        out_reg <= res_decided ? (res_gt ? CMP_GT : CMP_LT) : CMP_EQ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready         = (state_reg == IDLE);
    assign busy          = (state_reg == COMPARE);
    assign done          = (state_reg == DONE);
    assign out           = out_reg;
    assign bits_examined = bits_reg;

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
Parametrised, multi-cycle magnitude comparator; successor to the 2-bit combinational comparator. Captures two WIDTH-bit operands on a start handshake and compares them MSB-first, one bit per clock, in unsigned or two's-complement signed mode. It can terminate early on the first differing bit. Reports the result on the same one-hot {gt, eq, lt} output encoding the team's comparators already use, plus a done pulse. Sits in datapaths where area matters more than latency and operands are wide.

Parameters:
WIDTH, 8, operand width in bits; legal range 1..64.
EARLY_EXIT, 1, 1 = finish on first differing bit; 0 = always examine all WIDTH bits (constant latency).

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when ready=1.
signed_mode  input  1  1 = operands are two's complement; captured with start.
A  input  WIDTH  operand A; captured with start.
B  input  WIDTH  operand B; captured with start.
ready  output  1  high in IDLE only (combinational from state).
busy  output  1  high in COMPARE only.
done  output  1  one-cycle pulse, high in DONE state.
out  output  3  {A>B, A==B, A<B}, registered, one-hot once valid.
bits_examined  output  $clog2(WIDTH+1)  number of bit positions evaluated for the latest result.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, out=3'b000, done=0, busy=0, ready=1, bits_examined=0, internal operand registers cleared. Reset wins over every other event, including mid-COMPARE (abort, no done pulse).
- States:
  - IDLE: if start, capture A, B, signed_mode; idx=WIDTH-1; decided=0; bits_examined=0; go COMPARE. out holds its previous value until the capture edge, then clears to 000.
  - COMPARE: each edge evaluates bit idx and increments bits_examined.
    - If a differing bit is found and decided=0, record gt/lt and set decided=1.
    - Normal bit: A[idx]=1, B[idx]=0 means gt.
    - MSB with signed_mode=1: polarity inverted (A[MSB]=1, B[MSB]=0 means lt).
    - Exit to DONE when (EARLY_EXIT=1 and a difference is found at this edge) or idx==0; out written on that same edge.
    - If no difference was found, out=010.
    - If EARLY_EXIT=0, later differing bits never overwrite the first decision.
  - DONE: done=1 for exactly one cycle; next state IDLE unconditionally. start is ignored in DONE.
- Latency: start sampled at edge k. A result decided at the Nth examined bit produces out/DONE at edge k+N; done is high during cycle k+N to k+N+1. N=WIDTH when EARLY_EXIT=0 or the operands are equal. Minimum issue interval is N+2 cycles.
- start while busy or in DONE: ignored; operand inputs changing during COMPARE have no effect.
- out is stable from DONE until the next accepted start.
- WIDTH=1: the single bit is the MSB; signed mode gives 1 < 0.
- No X on any output after reset.

Decomposition:
- Shared package cmp_pkg holds:
  - output encodings CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, CMP_NONE=3'b000;
  - state encoding IDLE/COMPARE/DONE (2-bit).
- One natural sub-module: cmp_shift_reg. It is a WIDTH-bit load/shift-left register pair presenting the current MSBs of A and B. The top level holds the FSM, idx counter, and decision logic.

Test Plan:
- Reset: rst=1 for 2 cycles, start=1 → out=000, done=0, busy=0, ready=1, bits_examined=0; start ignored during reset.
- Equal, unsigned: A=8'hA5, B=8'hA5 → busy for 8 cycles; done pulses one cycle at edge k+8; out=010; bits_examined=8.
- Early exit (EARLY_EXIT=1):
  - A=8'h80, B=8'h7F unsigned → out=100, done at edge k+1, bits_examined=1.
  - Same operands with signed_mode=1 → out=001.
- Late difference and constant latency:
  - A=8'h03, B=8'h02 unsigned → out=100, bits_examined=8.
  - EARLY_EXIT=0 instance, A=8'h80, B=8'h00 → out=100, done still at k+8, first decision kept.
- Ignored inputs and abort:
  - During COMPARE, pulse start with A=8'h00, B=8'hFF → no effect on result.
  - Separate run: assert rst at bit 4 → next cycle IDLE, out=000, no done pulse ever.
- Back-to-back: start held high, operand pairs (5,9), (9,5) → results 001 then 100; each done exactly one cycle; second op accepted in the IDLE cycle after DONE.
